// File: rtl/pong_engine.sv
// Pong game core: one ball, one or two paddles, scores and the serve/play/game-over sequence.
// Motion advances on tick when not paused. The pixel colour is registered from the current coordinate.
module pong_engine #(
  parameter int NUM_PLAYERS = 2,
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 600,
  parameter int BALL_W      = 14,
  parameter int BALL_H      = 20,
  parameter int PAD_W       = 20,
  parameter int PAD_H       = 100,
  parameter int PAD_MARGIN  = 41,
  parameter int PAD_STEP    = 4,
  parameter int BALL_DX     = 6,
  parameter int BALL_DY     = 4,
  parameter int SCORE_MAX   = 9,
  parameter int SERVE_TICKS = 60
) (
  input  logic        CLK_100MHz,
  input  logic        Reset,
  input  logic        tick,
  input  logic        start,
  input  logic        pause,
  input  logic [1:0]  up,
  input  logic [1:0]  down,
  input  logic [11:0] ball_rgb,
  input  logic [10:0] CurrentX,
  input  logic [10:0] CurrentY,
  input  logic        HBlank,
  input  logic        VBlank,
  output logic [3:0]  RED,
  output logic [3:0]  GREEN,
  output logic [3:0]  BLUE,
  output logic [1:0]  state,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r
);

  typedef logic signed [11:0] s12_t;
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

  localparam int CW = $clog2(SERVE_TICKS) + 1;

  localparam s12_t ZERO       = '0;
  localparam s12_t H_ACT_S    = s12_t'(H_ACTIVE);
  localparam s12_t BALL_W_S   = s12_t'(BALL_W);
  localparam s12_t BALL_H_S   = s12_t'(BALL_H);
  localparam s12_t PAD_W_S    = s12_t'(PAD_W);
  localparam s12_t PAD_H_S    = s12_t'(PAD_H);
  localparam s12_t PAD_STEP_S = s12_t'(PAD_STEP);
  localparam s12_t BALL_DX_S  = s12_t'(BALL_DX);
  localparam s12_t BALL_DY_S  = s12_t'(BALL_DY);
  localparam s12_t PAD_R_X    = s12_t'(H_ACTIVE - PAD_MARGIN - PAD_W);
  localparam s12_t PAD_L_X    = s12_t'(PAD_MARGIN);
  localparam s12_t PAD_L_EDGE = s12_t'(PAD_MARGIN + PAD_W);
  localparam s12_t BALL_Y_MAX = s12_t'(V_ACTIVE - BALL_H);
  localparam s12_t PAD_Y_MAX  = s12_t'(V_ACTIVE - PAD_H);

  localparam logic [10:0]   BALL_X0   = 11'((H_ACTIVE - BALL_W) / 2);
  localparam logic [10:0]   BALL_Y0   = 11'((V_ACTIVE - BALL_H) / 2);
  localparam logic [10:0]   PAD_Y0    = 11'((V_ACTIVE - PAD_H) / 2);
  localparam logic [3:0]    WIN_SCORE = 4'(SCORE_MAX);
  localparam logic [CW-1:0] SERVE_END = CW'(SERVE_TICKS - 1);

  state_t        cur_st, nxt_st;
  logic [10:0]   ball_x, ball_y, pad_r_y, pad_l_y;
  logic          dx_neg, dy_neg;
  logic [CW-1:0] serve_cnt;
  logic [11:0]   rgb;

  logic          step, pads_live;
  logic [10:0]   pad_r_nxt, pad_l_nxt;
  s12_t          sx, sy, nx, ny, nx_cl, ny_cl;
  logic          dx_nxt, dy_nxt, ov_r, ov_l;
  logic          point_l, point_r, game_won;
  logic          in_ball, in_pad_r, in_pad_l;
  s12_t          cx, cy;

  function automatic s12_t ext(input logic [10:0] v);
    return signed'({1'b0, v});
  endfunction

  // Both buttons held cancel out; the result never leaves the screen.
  function automatic logic [10:0] pad_move(input logic [10:0] y, input logic u, input logic d);
    s12_t t;
    t = ext(y);
    if (u && !d)      t = t - PAD_STEP_S;
    else if (d && !u) t = t + PAD_STEP_S;
    if (t < ZERO)           t = ZERO;
    else if (t > PAD_Y_MAX) t = PAD_Y_MAX;
    return t[10:0];
  endfunction

  assign step = tick && !pause;

  // State register.
  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) cur_st <= IDLE;
    else        cur_st <= nxt_st;
  end

  // Next-state logic; start overrides everything, including a coincident tick.
  always_comb begin
    nxt_st = cur_st;
    if (start) begin
      nxt_st = SERVE;
    end else if (step) begin
      case (cur_st)
        SERVE:   if (serve_cnt == SERVE_END) nxt_st = PLAY;
        PLAY:    if (point_l || point_r) nxt_st = game_won ? OVER : SERVE;
        default: nxt_st = cur_st;
      endcase
    end
  end

  // Outputs decoded from the state and the registered pixel.
  always_comb begin
    state     = cur_st;
    pads_live = (cur_st == SERVE) || (cur_st == PLAY);
    RED       = rgb[11:8];
    GREEN     = rgb[7:4];
    BLUE      = rgb[3:0];
  end

  // Candidate motion for this tick, all in 12-bit signed so edges near 0 cannot wrap.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    pad_r_nxt = pad_r_y;
    pad_l_nxt = pad_l_y;
    if (pads_live) begin
      pad_r_nxt = pad_move(pad_r_y, up[0], down[0]);
      if (NUM_PLAYERS == 2) pad_l_nxt = pad_move(pad_l_y, up[1], down[1]);
    end

    sx = ext(ball_x);
    sy = ext(ball_y);
    nx = dx_neg ? sx - BALL_DX_S : sx + BALL_DX_S;
    ny = dy_neg ? sy - BALL_DY_S : sy + BALL_DY_S;

    ny_cl  = ny;
    dy_nxt = dy_neg;
    if (ny < ZERO) begin
      ny_cl  = ZERO;
      dy_nxt = ~dy_neg;
    end else if (ny > BALL_Y_MAX) begin
      ny_cl  = BALL_Y_MAX;
      dy_nxt = ~dy_neg;
    end

    // Vertical overlap uses the paddle positions being written this same tick.
    ov_r = (ny_cl < ext(pad_r_nxt) + PAD_H_S) && (ny_cl + BALL_H_S > ext(pad_r_nxt));
    ov_l = (ny_cl < ext(pad_l_nxt) + PAD_H_S) && (ny_cl + BALL_H_S > ext(pad_l_nxt));

    nx_cl   = nx;
    dx_nxt  = dx_neg;
    point_l = 1'b0;
    point_r = 1'b0;
    if (!dx_neg) begin
      if ((nx + BALL_W_S >= PAD_R_X) && (sx + BALL_W_S <= PAD_R_X) && ov_r) begin
        nx_cl  = PAD_R_X - BALL_W_S;
        dx_nxt = 1'b1;
      end else if (nx + BALL_W_S >= H_ACT_S) begin
        point_l = 1'b1;
      end
    end else if (NUM_PLAYERS == 1) begin
      if (nx < ZERO) begin
        nx_cl  = ZERO;
        dx_nxt = 1'b0;
      end
    end else begin
      if ((nx <= PAD_L_EDGE) && (sx >= PAD_L_EDGE) && ov_l) begin
        nx_cl  = PAD_L_EDGE;
        dx_nxt = 1'b0;
      end else if (nx < ZERO) begin
        point_r = 1'b1;
      end
    end

    game_won = point_l ? (score_l + 4'd1 == WIN_SCORE) : (score_r + 4'd1 == WIN_SCORE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      ball_x    <= BALL_X0;
      ball_y    <= BALL_Y0;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
      pad_r_y   <= PAD_Y0;
      pad_l_y   <= PAD_Y0;
      score_l   <= '0;
      score_r   <= '0;
      serve_cnt <= '0;
    end else if (start) begin
      ball_x    <= BALL_X0;
      ball_y    <= BALL_Y0;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
      score_l   <= '0;
      score_r   <= '0;
      serve_cnt <= '0;
    end else if (step) begin
      pad_r_y <= pad_r_nxt;
      pad_l_y <= pad_l_nxt;
      case (cur_st)
        SERVE: serve_cnt <= (serve_cnt == SERVE_END) ? '0 : serve_cnt + 1'b1;
        PLAY: begin
          if (point_l || point_r) begin
            if (point_l) score_l <= score_l + 4'd1;
            if (point_r) score_r <= score_r + 4'd1;
            // Recentre and serve toward the side that just conceded.
            ball_x <= BALL_X0;
            ball_y <= BALL_Y0;
            dx_neg <= point_r;
            dy_neg <= dy_nxt;
          end else begin
            ball_x <= nx_cl[10:0];
            ball_y <= ny_cl[10:0];
            dx_neg <= dx_nxt;
            dy_neg <= dy_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel hit tests against the positions currently held.
  always_comb begin
    cx       = ext(CurrentX);
    cy       = ext(CurrentY);
    in_ball  = (cx >= sx) && (cx < sx + BALL_W_S) && (cy >= sy) && (cy < sy + BALL_H_S);
    in_pad_r = (cx >= PAD_R_X) && (cx < PAD_R_X + PAD_W_S) &&
               (cy >= ext(pad_r_y)) && (cy < ext(pad_r_y) + PAD_H_S);
    in_pad_l = (NUM_PLAYERS == 2) && (cx >= PAD_L_X) && (cx < PAD_L_X + PAD_W_S) &&
               (cy >= ext(pad_l_y)) && (cy < ext(pad_l_y) + PAD_H_S);
  end

  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset)                     rgb <= '0;
    else if (HBlank || VBlank)      rgb <= '0;
    else if (in_ball)               rgb <= ball_rgb;
    else if (in_pad_r || in_pad_l)  rgb <= 12'hFFF;
    else                            rgb <= '0;
  end

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: stimulus queues hand-computed expectations,
// a monitor on the falling clock edge pops and compares them against the DUT.
module tb_pong_engine;

  logic        clk = 1'b0;
  logic        reset_n, tick, start, pause, hblank, vblank;
  logic [1:0]  up, down;
  logic [11:0] ball_rgb;
  logic [10:0] cur_x, cur_y;
  logic [3:0]  red, green, blue, score_l, score_r;
  logic [1:0]  state;

  pong_engine dut (
    .CLK_100MHz(clk), .Reset(reset_n), .tick(tick), .start(start), .pause(pause),
    .up(up), .down(down), .ball_rgb(ball_rgb), .CurrentX(cur_x), .CurrentY(cur_y),
    .HBlank(hblank), .VBlank(vblank), .RED(red), .GREEN(green), .BLUE(blue),
    .state(state), .score_l(score_l), .score_r(score_r)
  );

  always #5 clk = ~clk;

  typedef enum {K_STATE, K_SCORE_L, K_SCORE_R, K_BALL_X, K_BALL_Y, K_PAD_R, K_PAD_L, K_RGB} kind_e;
  typedef struct {
    kind_e kind;
    int    expv;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic expect_v(input kind_e k, input int v, input string nm);
    exp_t e;
    e.kind = k;
    e.expv = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic expect_ball(input int x, input int y, input string nm);
    expect_v(K_BALL_X, x, {nm, "_x"});
    expect_v(K_BALL_Y, y, {nm, "_y"});
  endtask

  // Monitor: drains all queued expectations mid-cycle, away from the active edge.
  exp_t mon_e;
  int   mon_act;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        K_STATE:   mon_act = int'(state);
        K_SCORE_L: mon_act = int'(score_l);
        K_SCORE_R: mon_act = int'(score_r);
        K_BALL_X:  mon_act = int'(dut.ball_x);
        K_BALL_Y:  mon_act = int'(dut.ball_y);
        K_PAD_R:   mon_act = int'(dut.pad_r_y);
        K_PAD_L:   mon_act = int'(dut.pad_l_y);
        default:   mon_act = int'({red, green, blue});
      endcase
      n_cmp++;
      if (mon_act != mon_e.expv) begin
        n_bad++;
        $display("FAIL %s: got %0d, expected %0d", mon_e.name, mon_act, mon_e.expv);
      end
    end
  end

  task automatic do_tick();
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic start_pulse(input logic with_tick);
    @(posedge clk); #1 start = 1'b1; tick = with_tick;
    @(posedge clk); #1 start = 1'b0; tick = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input logic hb, input int expv, input string nm);
    @(posedge clk); #1 cur_x = 11'(x); cur_y = 11'(y); hblank = hb;
    @(posedge clk); #1 expect_v(K_RGB, expv, nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; tick = 1'b0; start = 1'b0; pause = 1'b0;
    up = 2'b00; down = 2'b00; ball_rgb = 12'hA5C;
    cur_x = '0; cur_y = '0; hblank = 1'b0; vblank = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    expect_v(K_STATE, 0, "rst_state");
    expect_v(K_SCORE_L, 0, "rst_score_l");
    expect_v(K_SCORE_R, 0, "rst_score_r");
    expect_ball(393, 290, "rst_ball");
    expect_v(K_PAD_R, 250, "rst_pad_r");
    expect_v(K_PAD_L, 250, "rst_pad_l");
    expect_v(K_RGB, 0, "rst_rgb");

    // Rendering at rest: ball (393,290) 14x20, right pad (739,250), left pad (41,250).
    pix(393, 290, 1'b0, 12'hA5C, "pix_ball_tl");
    pix(406, 309, 1'b0, 12'hA5C, "pix_ball_br");
    pix(407, 290, 1'b0, 0,       "pix_ball_right_out");
    pix(393, 310, 1'b0, 0,       "pix_ball_below_out");
    pix(739, 250, 1'b0, 12'hFFF, "pix_pad_r_tl");
    pix(758, 349, 1'b0, 12'hFFF, "pix_pad_r_br");
    pix(759, 250, 1'b0, 0,       "pix_pad_r_out");
    pix(41,  300, 1'b0, 12'hFFF, "pix_pad_l");
    pix(393, 290, 1'b1, 0,       "pix_hblank");
    @(posedge clk); #1 hblank = 1'b0;

    // IDLE ignores ticks and paddle buttons.
    down = 2'b01;
    ticks(3);
    expect_v(K_STATE, 0, "idle_hold_state");
    expect_v(K_PAD_R, 250, "idle_pad_hold");

    // start coincident with tick: start wins, nothing moves.
    start_pulse(1'b1);
    expect_v(K_STATE, 1, "start_to_serve");
    expect_v(K_PAD_R, 250, "start_no_motion");

    ticks(9);
    expect_v(K_PAD_R, 286, "serve_pad_down9");
    pause = 1'b1;
    ticks(11);
    pause = 1'b0;
    expect_v(K_PAD_R, 286, "pause_pad_frozen");
    expect_v(K_STATE, 1, "pause_state_serve");
    up = 2'b01;
    ticks(5);
    expect_v(K_PAD_R, 286, "pad_up_and_down");
    up = 2'b10; down = 2'b01;
    ticks(45);
    expect_v(K_STATE, 1, "serve_tick59");
    expect_v(K_PAD_R, 466, "serve_pad_r");
    expect_v(K_PAD_L, 70, "serve_pad_l");
    ticks(1);
    expect_v(K_STATE, 2, "serve_to_play_delayed");
    expect_ball(393, 290, "ball_held_serve");

    // PLAY, moving +x +y: X = 393+6k, Y = 290+4k.
    ticks(1);
    expect_ball(399, 294, "play_k1");
    ticks(7);
    expect_v(K_PAD_R, 500, "pad_r_clamp_bottom");
    ticks(8);
    expect_v(K_PAD_L, 2, "pad_l_at_2");
    ticks(1);
    expect_v(K_PAD_L, 0, "pad_l_clamp_top");
    ticks(3);
    expect_v(K_PAD_L, 0, "pad_l_stays_0");
    ticks(35);
    expect_ball(723, 510, "play_k55");
    ticks(1);
    expect_ball(725, 514, "right_pad_hit");
    up = 2'b00; down = 2'b00;
    ticks(1);
    expect_ball(719, 518, "after_hit_dx_neg");
    ticks(15);
    expect_ball(629, 578, "near_bottom");
    ticks(1);
    expect_ball(623, 580, "bottom_clamp");
    ticks(1);
    expect_ball(617, 576, "bottom_bounce_dy_neg");
    ticks(102);
    expect_ball(5, 168, "near_left_miss");
    ticks(1);
    expect_v(K_STATE, 1, "left_miss_serve");
    expect_v(K_SCORE_R, 1, "left_miss_score_r");
    expect_v(K_SCORE_L, 0, "left_miss_score_l");
    expect_ball(393, 290, "left_miss_recentre");

    // Second serve heads left and up; left pad at 0 returns it.
    ticks(60);
    expect_v(K_STATE, 2, "serve2_play");
    ticks(55);
    expect_ball(63, 70, "play2_k55");
    ticks(1);
    expect_ball(61, 66, "left_pad_hit");
    ticks(1);
    expect_ball(67, 62, "left_hit_dx_pos");
    ticks(15);
    expect_ball(157, 2, "near_top");
    ticks(1);
    expect_ball(163, 0, "top_clamp");
    ticks(1);
    expect_ball(169, 4, "top_bounce_dy_pos");
    ticks(102);
    expect_ball(781, 412, "near_right_miss");
    ticks(1);
    expect_v(K_STATE, 1, "right_miss_serve");
    expect_v(K_SCORE_L, 1, "right_miss_score_l");
    expect_v(K_SCORE_R, 1, "right_miss_score_r_kept");

    // Restart and lose nine straight points on the right (126 ticks each).
    start_pulse(1'b0);
    expect_v(K_STATE, 1, "restart_serve");
    expect_v(K_SCORE_L, 0, "restart_score_l");
    expect_v(K_SCORE_R, 0, "restart_score_r");
    up = 2'b01;
    ticks(60);
    up = 2'b00;
    expect_v(K_PAD_R, 260, "pad_r_moved_away");
    expect_v(K_STATE, 2, "game_play");
    ticks(66);
    expect_v(K_SCORE_L, 1, "game_point1");
    ticks(7 * 126);
    expect_v(K_SCORE_L, 8, "game_point8");
    expect_v(K_STATE, 1, "game_point8_serve");
    ticks(126);
    expect_v(K_SCORE_L, 9, "game_point9");
    expect_v(K_STATE, 3, "game_over");
    expect_ball(393, 290, "over_ball_centre");
    down = 2'b01;
    ticks(10);
    down = 2'b00;
    expect_v(K_STATE, 3, "over_hold_state");
    expect_v(K_SCORE_L, 9, "over_hold_score");
    expect_v(K_PAD_R, 260, "over_pad_frozen");
    expect_ball(393, 290, "over_ball_frozen");
    start_pulse(1'b0);
    expect_v(K_STATE, 1, "over_restart");
    expect_v(K_SCORE_L, 0, "over_restart_score_l");

    // Reset in the middle of play returns everything to the power-on state.
    ticks(60);
    ticks(5);
    expect_ball(423, 310, "pre_reset_ball");
    pix(423, 310, 1'b0, 12'hA5C, "pre_reset_pix");
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    expect_v(K_STATE, 0, "midreset_state");
    expect_v(K_SCORE_L, 0, "midreset_score_l");
    expect_v(K_SCORE_R, 0, "midreset_score_r");
    expect_ball(393, 290, "midreset_ball");
    expect_v(K_PAD_R, 250, "midreset_pad_r");
    expect_v(K_PAD_L, 250, "midreset_pad_l");
    expect_v(K_RGB, 0, "midreset_rgb");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
